// File: rtl/cvw.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cvw                                                                  |
// | Shared uncore types: configuration record and AHB data-phase states. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cvw;

  // Configuration record handed down to uncore blocks.
  typedef struct packed {
    int AHBW;
  } cvw_t;

  localparam cvw_t CVW_DEFAULT = '{AHBW: 32};

  // Data-phase state of the AHB subordinate multiplexer.
  typedef enum logic [1:0] {
    DP_NONE = 2'd0,
    DP_SLV  = 2'd1,
    DP_ERR1 = 2'd2,
    DP_ERR2 = 2'd3
  } ahbdp_state_t;

endpackage
`default_nettype wire

// File: rtl/ahb_onehot_check.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ahb_onehot_check                                                     |
// | Classifies a select vector as zero / one-hot and returns the index   |
// | of its set bit (meaningful only when one-hot).                       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ahb_onehot_check #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vec,
  output logic          zero,
  output logic          onehot,
  output logic [IW-1:0] index
);

  // Zero/one-hot test plus OR-reduction of the set bit positions.
  always_comb begin
    zero   = (vec == '0);
    onehot = !zero && ((vec & (vec - N'(1))) == '0);
    index  = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) index = index | IW'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/ahb_slave_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ahb_slave_mux                                                        |
// | AHB-Lite data-phase multiplexer and response generator: muxes the    |
// | selected subordinate back to the master, answers unmapped accesses   |
// | with a two-cycle ERROR, times out stuck wait states and quarantines  |
// | subordinates that hung until they finish the abandoned transfer.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ahb_slave_mux import cvw::*; #(
  parameter cvw_t P              = CVW_DEFAULT,
  parameter int   NSLAVES        = 8,
  parameter int   TIMEOUT_CYCLES = 1024,
  parameter int   ERR_UNMAPPED   = 1
) (
  input  logic                             HCLK,
  input  logic                             HRESETn,
  input  logic [NSLAVES-1:0]               HSEL,
  input  logic [1:0]                       HTRANS,
  input  logic [NSLAVES-1:0]               HREADYOUT_S,
  input  logic [NSLAVES-1:0]               HRESP_S,
  input  logic [NSLAVES-1:0][P.AHBW-1:0]   HRDATA_S,
  output logic [P.AHBW-1:0]                HRDATA,
  output logic                             HREADY,
  output logic                             HRESP,
  output logic [NSLAVES-1:0]               HSELD,
  output logic [NSLAVES-1:0]               Hung,
  output logic                             TimeoutEvt
);

  localparam int AHBW   = P.AHBW;
  localparam int IW     = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
  localparam bit TO_EN  = (TIMEOUT_CYCLES > 0);
  localparam int CW     = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LIMIT = TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

  ahbdp_state_t        state;
  logic [CW-1:0]       wait_cnt;

  logic                sel_zero;
  logic                sel_onehot;
  logic [IW-1:0]       sel_idx;
  logic                seld_zero;
  logic                seld_onehot;
  logic [IW-1:0]       seld_idx;
  logic                unused_flags;

  logic                slv_ready;
  logic                slv_resp;
  logic                sel_hung;
  logic                timeout;
  logic [NSLAVES-1:0]  hung_release;

  ahb_onehot_check #(.N(NSLAVES), .IW(IW)) u_sel_check (
    .vec    (HSEL),
    .zero   (sel_zero),
    .onehot (sel_onehot),
    .index  (sel_idx)
  );

  ahb_onehot_check #(.N(NSLAVES), .IW(IW)) u_seld_check (
    .vec    (HSELD),
    .zero   (seld_zero),
    .onehot (seld_onehot),
    .index  (seld_idx)
  );

  // An empty vector is simply "not one-hot" here, so the zero flags are spare.
  assign unused_flags = sel_zero ^ seld_zero;

  // Response of the subordinate owning the current data phase, plus decode helpers.
  always_comb begin
    slv_ready    = seld_onehot && HREADYOUT_S[seld_idx];
    slv_resp     = seld_onehot && HRESP_S[seld_idx];
    sel_hung     = |(HSEL & Hung);
    hung_release = HREADYOUT_S & ~HSELD;
    timeout      = TO_EN && (state == DP_SLV) && !slv_ready && (wait_cnt == CNT_LIMIT);
  end

  // Master-facing handshake depends only on state and subordinate inputs.
  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    case (state)
      DP_SLV: begin
        HREADY = slv_ready;
        HRESP  = slv_resp;
      end
      DP_ERR1: begin
        HREADY = 1'b0;
        HRESP  = 1'b1;
      end
      DP_ERR2: HRESP = 1'b1;
      default: ;
    endcase
  end

  // AND-OR read-data mux; HSELD is zero outside DP_SLV, so idle/error give 0.
  always_comb begin
    HRDATA = '0;
    for (int i = 0; i < NSLAVES; i++) begin
      HRDATA = HRDATA | (HRDATA_S[i] & {AHBW{HSELD[i]}});
    end
  end

  // Data-phase FSM, wait counter, quarantine mask and timeout pulse.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= DP_NONE;
      HSELD      <= '0;
      Hung       <= '0;
      wait_cnt   <= '0;
      TimeoutEvt <= 1'b0;
    end else begin
      TimeoutEvt <= timeout;
      // A timeout marks the stuck subordinate; it is released once it shows
      // ready while no longer owning the data phase.
      Hung <= (Hung & ~hung_release) | (timeout ? HSELD : '0);
      if (HREADY) begin
        wait_cnt <= '0;
        if (HTRANS[1] && sel_onehot && !sel_hung) begin
          state <= DP_SLV;
          HSELD <= HSEL;
        end else if (HTRANS[1] && (ERR_UNMAPPED != 0)) begin
          state <= DP_ERR1;
          HSELD <= '0;
        end else begin
          state <= DP_NONE;
          HSELD <= '0;
        end
      end else if (timeout) begin
        state    <= DP_ERR1;
        HSELD    <= '0;
        wait_cnt <= '0;
      end else if (state == DP_ERR1) begin
        state <= DP_ERR2;
      end else if (state == DP_SLV && TO_EN) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/ahb_slave_mux.md
Name: ahb_slave_mux

Overview:
- Parametrised AHB-Lite data-phase multiplexer and response generator for the uncore. Sits between the address decoder (one-hot HSEL) and NSLAVES AHB subordinates (RAM, boot ROM, APB bridge, external port, ...).
- Drives HRDATA/HREADY/HRESP back to the master and the shared HREADY to all subordinates.
- Beyond the fixed single-cycle-OKAY select register it generalises:
  - a compliant two-cycle ERROR response for unmapped or multi-hot accesses;
  - a per-transfer wait-state timeout;
  - quarantine of hung subordinates.

Parameters:
- P, cvw_t (required), configuration record; AHBW taken from P.AHBW.
- NSLAVES, 8, number of subordinate ports (1..32).
- TIMEOUT_CYCLES, 1024, wait-state limit per data phase; 0 disables timeout and quarantine.
- ERR_UNMAPPED, 1, 1 = two-cycle ERROR for unmapped/multi-hot; 0 = single-cycle OKAY with HRDATA=0.

Ports:
- HCLK  input  1  bus clock; all state on rising edge.
- HRESETn  input  1  reset, asynchronous, active-low.
- HSEL  input  NSLAVES  address-phase selects from decoder.
- HTRANS  input  2  master transfer type.
- HREADYOUT_S  input  NSLAVES  per-subordinate ready.
- HRESP_S  input  NSLAVES  per-subordinate response.
- HRDATA_S  input  NSLAVES x AHBW  per-subordinate read data (packed array).
- HRDATA  output  AHBW  muxed read data.
- HREADY  output  1  to master and all subordinates.
- HRESP  output  1  to master.
- HSELD  output  NSLAVES  registered data-phase select.
- Hung  output  NSLAVES  sticky quarantine mask.
- TimeoutEvt  output  1  single-cycle pulse on a timeout.

Behaviour:
- Reset: state=DP_NONE, HSELD=0, Hung=0, counter=0, TimeoutEvt=0. HREADY=1, HRESP=0, HRDATA=0 during and immediately after reset. Reset mid-transfer abandons it without an error response.
- Active address phase: HTRANS[1]=1 (NONSEQ/SEQ). An address phase is accepted only in a cycle where HREADY=1.
- Data-phase FSM, next state on accepted phase:
  - DP_SLV(i) when HSEL is one-hot at bit i and Hung[i]=0.
  - DP_ERR1 when active and (HSEL==0, HSEL multi-hot, or Hung[i]=1) and ERR_UNMAPPED=1.
  - DP_NONE otherwise, including IDLE/BUSY, or unmapped with ERR_UNMAPPED=0.
- DP_NONE: HREADY=1, HRESP=0, HRDATA=0.
- DP_SLV(i): HREADY=HREADYOUT_S[i], HRESP=HRESP_S[i], HRDATA=HRDATA_S[i] (AND-OR mux on HSELD). Subordinate two-cycle errors pass through unchanged.
- DP_ERR1: HREADY=0, HRESP=1. Always advances to DP_ERR2.
- DP_ERR2: HREADY=1, HRESP=1. Accepts the next address phase.
- HSELD: one-hot of i in DP_SLV(i), else 0. Updated only when HREADY=1 or on a timeout.
- Timeout counter, width $clog2(TIMEOUT_CYCLES+1):
  - Clears on every accepted address phase.
  - Increments each DP_SLV cycle with HREADYOUT_S[i]=0.
  - When it equals TIMEOUT_CYCLES-1 with HREADYOUT_S[i] still 0: next state DP_ERR1, HSELD cleared, Hung[i] set, TimeoutEvt=1 for one cycle.
  - If HREADYOUT_S[i] rises in the same cycle as the limit, ready wins: normal completion, no timeout.
- Quarantine: Hung[k] clears in any cycle where HREADYOUT_S[k]=1 and HSELD[k]=0, i.e. the subordinate has finished its abandoned transfer. A new access to k in that same cycle still errors (mask sampled before update).
- Simultaneous: accepting a new address in DP_ERR2 or on a DP_SLV completion is a back-to-back transfer with no bubble. HTRANS changing to IDLE during DP_ERR1 is legal and ignored.
- No combinational path from HSEL/HTRANS to HREADY/HRESP; outputs depend only on state and subordinate inputs.

Decomposition:
- Package cvw: add typedef enum logic [1:0] {DP_NONE, DP_SLV, DP_ERR1, DP_ERR2} ahbdp_state_t.
- One sub-module, ahb_onehot_check: NSLAVES-wide vector to {zero, onehot, index}. Used for HSEL decode and HSELD index.
- The rest (FSM, counter, mux, Hung register) stays in ahb_slave_mux, approximately 200 lines.

Test Plan:
- Reset then NONSEQ to slave 2 with HREADYOUT_S[2]=1 and HRDATA_S[2]=0xDEAD_BEEF -> next cycle HRDATA=0xDEADBEEF, HREADY=1, HRESP=0, HSELD=0x04.
- NONSEQ with HSEL=0, then HSEL=0x06 (multi-hot) -> each yields HREADY=0/HRESP=1 then HREADY=1/HRESP=1. With ERR_UNMAPPED=0: single-cycle OKAY, HRDATA=0.
- TIMEOUT_CYCLES=4, slave 1 holds HREADYOUT low -> HREADY low 4 cycles, TimeoutEvt pulse, two-cycle ERROR, Hung=0x02. Next access to slave 1 errors. After HREADYOUT_S[1] rises, Hung=0 and the following access returns OKAY.
- Slave 3 raises HREADYOUT exactly in limit cycle (TIMEOUT_CYCLES=4, ready on 4th wait cycle) -> OKAY completion, no TimeoutEvt, Hung unchanged.
- Back-to-back NONSEQ slave 0 -> unmapped -> slave 5, all zero-wait -> responses OKAY, ERR, ERR, OKAY in consecutive cycles with no bubble; IDLE interleaved gives HREADY=1/HRESP=0.
- Assert HRESETn low during DP_SLV wait and during DP_ERR1 -> outputs immediately HREADY=1, HRESP=0, HSELD=0, Hung=0; first post-reset transfer completes normally.
